// File: rtl/vblank_update_scheduler_pkg.sv
// Shared definitions for the vblank update scheduler: FSM encoding and
// VGA 800x600@60 timing constants.
package vblank_update_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARB       = 2'd1,
        ST_GRANT     = 2'd2,
        ST_DONE_WAIT = 2'd3
    } sched_state_e;

    localparam int DEF_MAX_GRANT_CYC = 4096;
    localparam int VGA_VBLANK_LINES  = 28;
    localparam int VGA_H_TOTAL       = 1056;

endpackage

// File: rtl/vblank_update_scheduler_rr_arbiter.sv
// Round-robin selector: picks the first pending requester at or above the
// pointer, wrapping modulo N_REQ.
module vblank_update_scheduler_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] sel,
    output logic [IW-1:0]    sel_idx,
    output logic             valid
);

    logic [IW-1:0] j_s;

    // scan N_REQ positions starting from the pointer, first hit wins
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        valid   = 1'b0;
        j_s     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j_s = IW'((int'(rr_ptr) + k) % N_REQ);
            if (!valid && pending[j_s]) begin
                valid      = 1'b1;
                sel[j_s]   = 1'b1;
                sel_idx    = j_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Schedules one-at-a-time per-frame update grants inside vertical blanking,
// with frame counting, per-grant watchdog and overrun reporting.
module vblank_update_scheduler
    import vblank_update_scheduler_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int MAX_GRANT_CYC = DEF_MAX_GRANT_CYC,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   vblnk_in,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       gnt,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun,
    output logic [N_REQ-1:0]       timeout_err,
    output logic                   busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = (MAX_GRANT_CYC > 2) ? $clog2(MAX_GRANT_CYC) : 1;

    sched_state_e           state_q, state_d;
    logic                   vblnk_q;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [N_REQ-1:0]       served_q, served_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic [N_REQ-1:0]       timeout_q, timeout_d;
    logic [WW-1:0]          wdog_q, wdog_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   frame_start_q, frame_start_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    logic                   rise_s, fall_s, done_s, wd_exp_s, arb_valid_s;
    logic [N_REQ-1:0]       pending_s, arb_sel_s, gidx_oh_s;
    logic [IW-1:0]          arb_idx_s, next_ptr_s;

    assign rise_s     = vblnk_in & ~vblnk_q;
    assign fall_s     = ~vblnk_in & vblnk_q;
    assign pending_s  = req & ~served_q;
    assign done_s     = done[gidx_q];
    assign wd_exp_s   = (wdog_q == WW'(MAX_GRANT_CYC - 1));
    assign gidx_oh_s  = {{(N_REQ-1){1'b0}}, 1'b1} << gidx_q;
    assign next_ptr_s = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);

    vblank_update_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .pending (pending_s),
        .rr_ptr  (rr_ptr_q),
        .sel     (arb_sel_s),
        .sel_idx (arb_idx_s),
        .valid   (arb_valid_s)
    );

    // next-state: vblank rise restarts arbitration from any state
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gidx_d        = gidx_q;
        served_d      = served_q;
        rr_ptr_d      = rr_ptr_q;
        wdog_d        = wdog_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_d     = timeout_q;
        frame_start_d = 1'b0;
        overrun_d     = 1'b0;
        if (rise_s) begin
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + FRAME_CNT_W'(1);
            served_d      = '0;
            gnt_d         = '0;
            state_d       = ST_ARB;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ARB: begin
                    if (!vblnk_in) begin
                        state_d = ST_IDLE;
                    end else if (arb_valid_s) begin
                        gnt_d   = arb_sel_s;
                        gidx_d  = arb_idx_s;
                        wdog_d  = '0;
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_DONE_WAIT;
                    end
                end
                ST_GRANT: begin
                    wdog_d = wdog_q + WW'(1);
                    if (done_s || fall_s || wd_exp_s) begin
                        gnt_d    = '0;
                        served_d = served_q | gidx_oh_s;
                        rr_ptr_d = next_ptr_s;
                        // done wins over fall (no overrun), fall wins over watchdog
                        if (done_s) begin
                            state_d = fall_s ? ST_IDLE : ST_ARB;
                        end else if (fall_s) begin
                            overrun_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            timeout_d = timeout_q | gidx_oh_s;
                            state_d   = ST_ARB;
                        end
                    end else begin
                        state_d = ST_GRANT;
                    end
                end
                ST_DONE_WAIT: state_d = fall_s ? ST_IDLE : ST_DONE_WAIT;
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == ST_ARB) || (state_d == ST_GRANT);
    end

    // state and output registers; vblnk_q resets high to suppress a false rise
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            vblnk_q       <= 1'b1;
            rr_ptr_q      <= '0;
            gidx_q        <= '0;
            served_q      <= '0;
            gnt_q         <= '0;
            timeout_q     <= '0;
            wdog_q        <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vblnk_q       <= vblnk_in;
            rr_ptr_q      <= rr_ptr_d;
            gidx_q        <= gidx_d;
            served_q      <= served_d;
            gnt_q         <= gnt_d;
            timeout_q     <= timeout_d;
            wdog_q        <= wdog_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign gnt         = gnt_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Randomized bench for vblank_update_scheduler against a cycle-level
// behavioural model of grants, frames, watchdog and overrun.
module tb_vblank_update_scheduler;
    import vblank_update_scheduler_pkg::*;

    localparam int N    = 4;
    localparam int MAXG = 4096;
    localparam int FW   = 4;

    logic          pclk = 1'b0;
    logic          rst = 1'b0;
    logic          vblnk_in = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  done = '0;
    logic [N-1:0]  gnt;
    logic          frame_start;
    logic [FW-1:0] frame_cnt;
    logic          overrun;
    logic [N-1:0]  timeout_err;
    logic          busy;

    vblank_update_scheduler #(
        .N_REQ         (N),
        .MAX_GRANT_CYC (MAXG),
        .FRAME_CNT_W   (FW)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .vblnk_in    (vblnk_in),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_err = 0;

    // model: holder = index currently granted (-1 none), pick = arbitrate next clock
    int       m_vq, m_holder, m_pick, m_ptr, m_wd, m_cnt, m_fs, m_ov;
    bit [N-1:0] m_served, m_to;

    // stimulus policy
    int dly = 5;
    int stuck = -1;
    bit noise_en = 1'b0;
    bit fall_done = 1'b0;
    int gq[$];
    int ov_seen = 0;
    logic [N-1:0] prev_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_vq = 1; m_holder = -1; m_pick = 0; m_ptr = 0; m_wd = 0;
        m_cnt = 0; m_fs = 0; m_ov = 0; m_served = '0; m_to = '0;
    endtask

    task automatic m_step();
        int  h;
        bit  v, rise, fall;
        v    = vblnk_in;
        rise = v && (m_vq == 0);
        fall = !v && (m_vq != 0);
        m_fs = 0;
        m_ov = 0;
        if (rise) begin
            m_fs = 1;
            m_cnt = (m_cnt + 1) % (1 << FW);
            m_served = '0;
            m_holder = -1;
            m_pick = 1;
        end else if (m_pick != 0) begin
            m_pick = 0;
            if (v) begin
                for (int k = 0; k < N; k++) begin
                    h = (m_ptr + k) % N;
                    if (m_holder < 0 && req[h] && !m_served[h]) begin
                        m_holder = h;
                        m_wd = 0;
                    end
                end
            end
        end else if (m_holder >= 0) begin
            h = m_holder;
            if (done[h] || fall || m_wd == MAXG - 1) begin
                if (!done[h] && fall) m_ov = 1;
                else if (!done[h]) m_to[h] = 1'b1;
                m_pick = fall ? 0 : 1;
                m_served[h] = 1'b1;
                m_ptr = (h + 1) % N;
                m_holder = -1;
            end else begin
                m_wd++;
            end
        end
        m_vq = v;
    endtask

    always @(posedge pclk) if (rst) m_step();

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_holder >= 0) g[m_holder] = 1'b1;
        return g;
    endfunction

    function automatic int enc();
        int e;
        e = 0;
        for (int k = 0; k < gq.size() && k < 8; k++) e |= (gq[k] + 1) << (4 * k);
        return e;
    endfunction

    task automatic cyc();
        logic [N-1:0] d;
        logic         eb;
        @(negedge pclk);
        eb = (m_pick != 0) || (m_holder >= 0);
        chk("gnt", 32'(gnt), 32'(exp_gnt()));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("overrun", 32'(overrun), 32'(m_ov));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        chk("busy", 32'(busy), 32'(eb));
        if (overrun) ov_seen++;
        if (gnt !== '0 && gnt !== prev_gnt)
            for (int k = 0; k < N; k++) if (gnt[k]) gq.push_back(k);
        prev_gnt = gnt;
        d = noise_en ? N'($urandom & $urandom) : '0;
        if (m_holder >= 0) begin
            d[m_holder] = 1'b0;
            if (m_holder != stuck && m_wd == dly - 1) d[m_holder] = 1'b1;
        end
        done = d;
    endtask

    task automatic frame(input int vb, input int act);
        gq.delete();
        ov_seen = 0;
        for (int i = 0; i < vb; i++) begin
            cyc();
            vblnk_in = 1'b1;
        end
        for (int i = 0; i < act; i++) begin
            cyc();
            if (i == 0 && fall_done && m_holder >= 0) done[m_holder] = 1'b1;
            vblnk_in = 1'b0;
        end
    endtask

    initial begin
        int k;
        m_reset();
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        // vblank already high at reset release: no frame may start
        repeat (6) cyc();
        chk("no_spurious_cnt", 32'(frame_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin cyc(); vblnk_in = 1'b0; end

        req = 4'b1111; dly = 5;
        frame(VGA_VBLANK_LINES * 4, 30);
        chk("f1_order", 32'(enc()), 32'h4321);
        chk("f1_cnt", 32'(frame_cnt), 32'd1);

        req = 4'b0111; dly = 3;
        frame(60, 20);
        chk("rr_order_a", 32'(enc()), 32'h321);
        req = 4'b0101;
        frame(60, 20);
        chk("rr_order_b", 32'(enc()), 32'h31);

        req = 4'b0110; stuck = 1; dly = 4;
        frame(4200, 20);
        chk("wdog_order", 32'(enc()), 32'h32);
        chk("wdog_flag", 32'(timeout_err), 32'h2);

        req = 4'b0100; stuck = 2;
        frame(60, 20);
        chk("ovr_seen", 32'(ov_seen), 32'd1);
        req = 4'b1111; stuck = -1; dly = 5;
        frame(112, 20);
        chk("ovr_resume", 32'(enc()), 32'h3214);

        req = 4'b0001; stuck = 0; fall_done = 1'b1;
        frame(40, 20);
        chk("fall_done_no_ovr", 32'(ov_seen), 32'd0);
        chk("fall_done_grant", 32'(enc()), 32'h1);
        fall_done = 1'b0; stuck = -1;

        // asynchronous reset in the middle of a grant
        req = 4'b1111; dly = 8;
        cyc();
        vblnk_in = 1'b1;
        k = 0;
        while (m_holder < 0 && k < 20) begin cyc(); k++; end
        chk("rst_grant_reached", 32'(m_holder >= 0), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);
        m_reset();
        cyc(); cyc();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin cyc(); vblnk_in = 1'b0; end

        noise_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
            req   = N'($urandom);
            dly   = $urandom_range(1, 8);
            stuck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            frame($urandom_range(30, 80), $urandom_range(10, 30));
        end
        chk("wrap_cnt", 32'(frame_cnt), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
